// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt controller:
// cause codes, FSM encoding, decision payload and default vector.
package exc_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned CAUSE_W  = 4;
    localparam int unsigned IRQ_ID_W = 3;
    localparam int unsigned CNT_W    = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_IRQ  = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_SYS  = 4'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_ILL  = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_PRIV = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_OVF  = 4'd4;

    localparam logic [PC_W-1:0] EXC_VECTOR_BASE = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TAKE  = 2'd1,
        ST_RET   = 2'd2,
        ST_DRAIN = 2'd3
    } exc_state_t;

    // Outcome of the IDLE-cycle event decode
    typedef struct packed {
        logic                take;
        logic                ret;
        logic [CAUSE_W-1:0]  cause;
        logic [IRQ_ID_W-1:0] irq_id;
    } exc_dec_t;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for the external interrupt lines plus a
// lowest-index priority encoder over the synchronised requests.
module irq_sync
    import exc_pkg::*;
#(
    parameter int unsigned NIRQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NIRQ-1:0]     i_irq,
    output logic                o_irq_any_c,
    output logic [IRQ_ID_W-1:0] o_irq_id_c
);

    logic [NIRQ-1:0] r_meta;
    logic [NIRQ-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_irq;
            r_sync <= r_meta;
        end
    end

    // Scan downwards so the lowest set index wins
    always_comb begin
        o_irq_id_c = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (r_sync[i]) begin
                o_irq_id_c = IRQ_ID_W'(i);
            end
        end
    end

    assign o_irq_any_c = |r_sync;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: decodes faults and gated interrupts,
// strobes the status register and redirects fetch to the vector or EPC.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned     NIRQ         = 4,
    parameter logic [PC_W-1:0] VECTOR_BASE  = EXC_VECTOR_BASE,
    parameter int unsigned     DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NIRQ-1:0]     irq,
    input  logic                IE_c,
    input  logic                s_u_c,
    input  logic                inst_valid,
    input  logic [PC_W-1:0]     inst_pc,
    input  logic                syscall,
    input  logic                illegal,
    input  logic                priv_instr,
    input  logic                overflow,
    input  logic                rfe_instr,
    output logic                exception,
    output logic                rfe,
    output logic                flush,
    output logic                stall,
    output logic                pc_redirect,
    output logic [PC_W-1:0]     redirect_pc,
    output logic [PC_W-1:0]     epc,
    output logic [CAUSE_W-1:0]  cause,
    output logic [IRQ_ID_W-1:0] irq_id
);

    exc_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_exception, w_exception_nxt;
    logic                r_rfe, w_rfe_nxt;
    logic                r_flush, w_flush_nxt;
    logic                r_stall, w_stall_nxt;
    logic                r_pc_redirect, w_pc_redirect_nxt;
    logic [PC_W-1:0]     r_redirect_pc, w_redirect_pc_nxt;
    logic [PC_W-1:0]     r_epc, w_epc_nxt;
    logic [CAUSE_W-1:0]  r_cause, w_cause_nxt;
    logic [IRQ_ID_W-1:0] r_irq_id, w_irq_id_nxt;

    logic                w_irq_any;
    logic [IRQ_ID_W-1:0] w_irq_id;
    exc_dec_t            w_dec;

    irq_sync #(
        .NIRQ(NIRQ)
    ) u_irq_sync (
        .clk        (clk),
        .rst        (rst),
        .i_irq      (irq),
        .o_irq_any_c(w_irq_any),
        .o_irq_id_c (w_irq_id)
    );

    // Event priority: faults, then supervisor return, then gated interrupt
    always_comb begin
        w_dec = '0;
        if (inst_valid) begin
            if (illegal) begin
                w_dec.take  = 1'b1;
                w_dec.cause = CAUSE_ILL;
            end else if ((priv_instr || rfe_instr) && s_u_c) begin
                w_dec.take  = 1'b1;
                w_dec.cause = CAUSE_PRIV;
            end else if (syscall) begin
                w_dec.take  = 1'b1;
                w_dec.cause = CAUSE_SYS;
            end else if (overflow) begin
                w_dec.take  = 1'b1;
                w_dec.cause = CAUSE_OVF;
            end else if (rfe_instr) begin
                w_dec.ret   = 1'b1;
            end else if (w_irq_any && IE_c) begin
                w_dec.take   = 1'b1;
                w_dec.cause  = CAUSE_IRQ;
                w_dec.irq_id = w_irq_id;
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_exception_nxt   = 1'b0;
        w_rfe_nxt         = 1'b0;
        w_flush_nxt       = 1'b0;
        w_stall_nxt       = 1'b0;
        w_pc_redirect_nxt = 1'b0;
        w_redirect_pc_nxt = r_redirect_pc;
        w_epc_nxt         = r_epc;
        w_cause_nxt       = r_cause;
        w_irq_id_nxt      = r_irq_id;

        case (r_state)
            ST_IDLE: begin
                if (w_dec.take) begin
                    w_state_nxt       = ST_TAKE;
                    w_exception_nxt   = 1'b1;
                    w_flush_nxt       = 1'b1;
                    w_stall_nxt       = 1'b1;
                    w_pc_redirect_nxt = 1'b1;
                    w_redirect_pc_nxt = VECTOR_BASE;
                    w_epc_nxt         = inst_pc;
                    w_cause_nxt       = w_dec.cause;
                    w_irq_id_nxt      = w_dec.irq_id;
                end else if (w_dec.ret) begin
                    w_state_nxt       = ST_RET;
                    w_rfe_nxt         = 1'b1;
                    w_flush_nxt       = 1'b1;
                    w_stall_nxt       = 1'b1;
                    w_pc_redirect_nxt = 1'b1;
                    w_redirect_pc_nxt = r_epc;
                end
            end
            ST_TAKE, ST_RET: begin
                w_state_nxt = ST_DRAIN;
                w_cnt_nxt   = CNT_W'(DRAIN_CYCLES);
                w_stall_nxt = 1'b1;
            end
            ST_DRAIN: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_stall_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_exception   <= 1'b0;
            r_rfe         <= 1'b0;
            r_flush       <= 1'b0;
            r_stall       <= 1'b0;
            r_pc_redirect <= 1'b0;
            r_redirect_pc <= '0;
            r_epc         <= '0;
            r_cause       <= '0;
            r_irq_id      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_exception   <= w_exception_nxt;
            r_rfe         <= w_rfe_nxt;
            r_flush       <= w_flush_nxt;
            r_stall       <= w_stall_nxt;
            r_pc_redirect <= w_pc_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_epc         <= w_epc_nxt;
            r_cause       <= w_cause_nxt;
            r_irq_id      <= w_irq_id_nxt;
        end
    end

    assign exception   = r_exception;
    assign rfe         = r_rfe;
    assign flush       = r_flush;
    assign stall       = r_stall;
    assign pc_redirect = r_pc_redirect;
    assign redirect_pc = r_redirect_pc;
    assign epc         = r_epc;
    assign cause       = r_cause;
    assign irq_id      = r_irq_id;

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt controller: the initiator side of the status-register interface.
- Decodes synchronous faults and external interrupt requests, and gates interrupts using IE_c and s_u_c from the status register.
- Drives the status register's exception and rfe strobes and redirects the fetch PC to the handler vector or back to EPC.
- Holds EPC and cause for the handler; sits between the decode/execute stage and the fetch PC mux.

Parameters:
NIRQ, 4, number of external interrupt lines (1..8)
VECTOR_BASE, 32'h0000_0080, handler entry address for every exception/interrupt
DRAIN_CYCLES, 2, stall cycles after any exception/rfe strobe so the status-register update is visible before the next decision (1..7)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
irq  in  NIRQ  level interrupt requests, asynchronous to clk
IE_c  in  1  interrupt enable from status register (1 = enabled)
s_u_c  in  1  mode from status register (1 = user, 0 = supervisor)
inst_valid  in  1  instruction in execute stage is valid
inst_pc  in  32  PC of that instruction
syscall  in  1  instruction is SYSCALL
illegal  in  1  instruction is undecodable
priv_instr  in  1  instruction is supervisor-only
overflow  in  1  arithmetic overflow on that instruction
rfe_instr  in  1  instruction is RFE
exception  out  1  one-cycle strobe to status register
rfe  out  1  one-cycle strobe to status register
flush  out  1  squash execute-stage instruction this cycle
stall  out  1  freeze pipeline
pc_redirect  out  1  fetch must load redirect_pc this cycle
redirect_pc  out  32  target PC
epc  out  32  saved PC of the excepting/interrupted instruction
cause  out  4  0 irq, 1 syscall, 2 illegal, 3 privilege, 4 overflow
irq_id  out  3  lowest-numbered pending irq at take time (0 if cause != 0)

Behaviour:
- Reset (async, rst=1): state IDLE; all strobes, flush, stall, pc_redirect = 0; redirect_pc, epc = 0; cause, irq_id = 0; synchronisers cleared.
- irq passes through a 2-flop synchroniser; pending = irq_sync & {NIRQ{IE_c}}.
- Inputs other than irq are evaluated only in IDLE with inst_valid=1.
- Event priority, highest first:
  1. illegal -> cause 2.
  2. priv_instr or rfe_instr with s_u_c=1 -> cause 3 (a user RFE faults and does not strobe rfe).
  3. syscall -> cause 1.
  4. overflow -> cause 4.
  5. rfe_instr with s_u_c=0 -> return.
  6. pending != 0 -> cause 0.
- Synchronous faults beat a simultaneous interrupt; a supervisor rfe beats a simultaneous interrupt, which is re-evaluated after drain using the restored IE_c.
- FSM states: IDLE, TAKE, RET, DRAIN.
- IDLE -> TAKE on any fault/irq. TAKE (1 cycle):
  - exception=1, flush=1, stall=1, pc_redirect=1, redirect_pc=VECTOR_BASE.
  - epc<=inst_pc, cause/irq_id latched from the IDLE-cycle decision.
- IDLE -> RET on supervisor rfe. RET (1 cycle):
  - rfe=1, flush=1, stall=1, pc_redirect=1, redirect_pc=epc.
  - epc and cause unchanged.
- TAKE/RET -> DRAIN: stall=1 for DRAIN_CYCLES cycles (3-bit down-counter), then IDLE. No events are sampled in DRAIN; irq stays visible because it is level-sensitive.
- epc for an interrupt = PC of the squashed (not executed) instruction; the handler re-executes it. For a syscall the handler adds 4.
- Exception and rfe are never high in the same cycle.
- Exception while already in supervisor mode (nested fault) is taken normally; epc is overwritten.
- inst_valid=0 in IDLE: nothing taken, even with pending irq.
- Reset mid-TAKE/DRAIN: immediate return to IDLE with reset values; no partial strobe completes.

Decomposition:
- Shared package (exc_pkg): cause codes (CAUSE_IRQ=0, CAUSE_SYS=1, CAUSE_ILL=2, CAUSE_PRIV=3, CAUSE_OVF=4), FSM state encoding, VECTOR_BASE default.
- One sub-module irq_sync: 2-flop synchroniser plus lowest-index priority encoder producing irq_any and irq_id.

Test Plan:
- Reset, then inst_valid=1, inst_pc=32'h100, syscall=1 -> next cycle exception=1, redirect_pc=32'h80, then epc=32'h100, cause=1; stall high 1+2 cycles.
- IE_c=1, irq=4'b0110 held, inst_pc=32'h200 -> after 2 sync cycles TAKE: cause=0, irq_id=1, epc=32'h200; same irq with IE_c=0 -> nothing taken.
- s_u_c=1, rfe_instr=1, inst_pc=32'h300 -> exception=1, cause=3, rfe stays 0; s_u_c=0, rfe_instr=1 -> rfe=1, redirect_pc=epc, exception=0.
- rfe_instr (supervisor) with irq pending in the same cycle -> RET first; after DRAIN with IE_c=1, TAKE with cause=0.
- illegal=1 and overflow=1 together -> cause=2; rst pulsed during DRAIN -> stall=0 and epc=0 immediately, state IDLE.
